cdb_arbiter: RTL and testbench

- Shares the common data bus between the functional units: the four ALU reservation-station/ALU pairs and the load/store unit.
- Each requester owns a one-entry result holding buffer.
- Each cycle up to NUM_PORTS buffered results are broadcast (tag plus data) on the CDB write ports, chosen by a rotating round-robin priority.
- Back-pressure goes to the requesters through per-requester ready signals. A flush input discards all pending results on mispredict recovery.

---
 rtl/cdb_arbiter_if.sv | 36 +++
 rtl/cdb_arbiter.sv | 121 ++++++++++++
 tb/tb_cdb_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Bundle between the functional-unit requesters and the CDB arbiter: result
// requests in, broadcast ports and occupancy/pointer visibility out.
interface cdb_arbiter_if #(
    parameter int NUM_REQ   = 5,
    parameter int NUM_PORTS = 2,
    parameter int TAG_W     = 3,
    parameter int DATA_W    = 32
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: requester i's result (req_tag[i], req_data[i]) is transferred
    // on a rising edge where req_valid[i] && req_ready[i]; req_tag/req_data
    // are don't-care while req_valid is low. cdb_* has no ready: a broadcast
    // is complete in the cycle cdb_valid[p] is high.
    logic                              flush;
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0][TAG_W-1:0]     req_tag;
    logic [NUM_REQ-1:0][DATA_W-1:0]    req_data;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_PORTS-1:0]              cdb_valid;
    logic [NUM_PORTS-1:0][TAG_W-1:0]   cdb_tag;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  cdb_data;
    logic [(2**TAG_W)-1:0]             tag_done;
    logic [NUM_REQ-1:0]                pending;
    logic [PTR_W-1:0]                  rr_ptr;

    modport master (
        output flush, req_valid, req_tag, req_data,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, tag_done, pending, rr_ptr
    );

    modport slave (
        input  flush, req_valid, req_tag, req_data,
        output req_ready, cdb_valid, cdb_tag, cdb_data, tag_done, pending, rr_ptr
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry result buffer per requester, up to
// NUM_PORTS broadcasts per cycle chosen by a rotating round-robin pointer.
module cdb_arbiter #(
    parameter int NUM_REQ   = 5,
    parameter int NUM_PORTS = 2,
    parameter int TAG_W     = 3,
    parameter int DATA_W    = 32
) (
    input  logic           clk,
    input  logic           rst,
    cdb_arbiter_if.slave   bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(NUM_PORTS + 1);

    logic [NUM_REQ-1:0]               buf_v_q, buf_v_d;
    logic [NUM_REQ-1:0][TAG_W-1:0]    buf_tag_q, buf_tag_d;
    logic [NUM_REQ-1:0][DATA_W-1:0]   buf_data_q, buf_data_d;
    logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;

    logic                             halt;
    logic [NUM_REQ-1:0]               grant;
    logic                             any_grant;
    logic [PTR_W-1:0]                 last_idx;
    logic [PTR_W:0]                   scan;
    logic [CNT_W-1:0]                 cnt;
    logic [NUM_PORTS-1:0]             cdb_valid;
    logic [NUM_PORTS-1:0][TAG_W-1:0]  cdb_tag;
    logic [NUM_PORTS-1:0][DATA_W-1:0] cdb_data;
    logic [(2**TAG_W)-1:0]            tag_done;
    logic [NUM_REQ-1:0]               req_ready;

    // Reset is gated in as well so buffered results are dropped, never broadcast.
    assign halt = bus.flush | rst;

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        last_idx  = rr_ptr_q;
        scan      = '0;
        cnt       = '0;
        cdb_valid = '0;
        cdb_tag   = '0;
        cdb_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (scan >= (PTR_W+1)'(NUM_REQ)) scan = scan - (PTR_W+1)'(NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (scan == (PTR_W+1)'(i) && buf_v_q[i] && !halt &&
                    cnt < CNT_W'(NUM_PORTS)) begin
                    grant[i] = 1'b1;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (cnt == CNT_W'(p)) begin
                            cdb_valid[p] = 1'b1;
                            cdb_tag[p]   = buf_tag_q[i];
                            cdb_data[p]  = buf_data_q[i];
                        end
                    end
                    cnt       = cnt + CNT_W'(1);
                    last_idx  = PTR_W'(i);
                    any_grant = 1'b1;
                end
            end
        end
    end

    always_comb begin
        tag_done = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (cdb_valid[p]) tag_done[cdb_tag[p]] = 1'b1;
        end
    end

    // A granted buffer drains this cycle, so it can take a new result on the same edge.
    assign req_ready = halt ? '0 : (~buf_v_q | grant);

    always_comb begin
        buf_v_d    = buf_v_q;
        buf_tag_d  = buf_tag_q;
        buf_data_d = buf_data_q;
        rr_ptr_d   = rr_ptr_q;
        if (bus.flush) begin
            buf_v_d = '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && req_ready[i]) begin
                    buf_v_d[i]    = 1'b1;
                    buf_tag_d[i]  = bus.req_tag[i];
                    buf_data_d[i] = bus.req_data[i];
                end else if (grant[i]) begin
                    buf_v_d[i] = 1'b0;
                end
            end
            if (any_grant) begin
                rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v_q    <= '0;
            buf_tag_q  <= '0;
            buf_data_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            buf_v_q    <= buf_v_d;
            buf_tag_q  <= buf_tag_d;
            buf_data_q <= buf_data_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.cdb_valid = cdb_valid;
    assign bus.cdb_tag   = cdb_tag;
    assign bus.cdb_data  = cdb_data;
    assign bus.tag_done  = tag_done;
    assign bus.pending   = buf_v_q;
    assign bus.rr_ptr    = rr_ptr_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a two-port and a one-port instance share stimulus and
// are each compared every cycle against a queue-based round-robin model.
module tb_cdb_arbiter;
    localparam int NR = 5;

    logic clk;
    logic rst;
    logic flush_r;
    logic [NR-1:0]       valid_r;
    logic [NR-1:0][2:0]  tag_r;
    logic [NR-1:0][31:0] data_r;

    int n_checks = 0;
    int n_errors = 0;

    cdb_arbiter_if #(.NUM_PORTS(2)) if0 ();
    cdb_arbiter_if #(.NUM_PORTS(1)) if1 ();

    assign if0.flush = flush_r;  assign if1.flush = flush_r;
    assign if0.req_valid = valid_r;  assign if1.req_valid = valid_r;
    assign if0.req_tag = tag_r;  assign if1.req_tag = tag_r;
    assign if0.req_data = data_r;  assign if1.req_data = data_r;

    cdb_arbiter #(.NUM_PORTS(2)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    cdb_arbiter #(.NUM_PORTS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state, per instance
    bit          mv[2][NR];
    logic [2:0]  mt[2][NR];
    logic [31:0] md[2][NR];
    int          mp[2];
    bit          m_init = 1'b0;

    logic [1:0]  e_cv[2];
    logic [5:0]  e_ct[2];
    logic [63:0] e_cd[2];
    logic [7:0]  e_td[2];
    logic [4:0]  e_rdy[2];
    logic [4:0]  e_pend[2];
    logic [2:0]  e_ptr[2];
    logic [4:0]  e_gm[2];
    int          e_last[2];

    logic [2:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_eval(input int d);
        int order[$];
        int np;
        bit halt;
        np = (d == 0) ? 2 : 1;
        halt = flush_r || rst;
        e_cv[d] = '0; e_ct[d] = '0; e_cd[d] = '0; e_td[d] = '0; e_gm[d] = '0;
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (mp[d] + k) % NR;
            if (mv[d][i] && !halt && order.size() < np) order.push_back(i);
        end
        foreach (order[p]) begin
            e_cv[d][p] = 1'b1;
            e_ct[d][p*3 +: 3] = mt[d][order[p]];
            e_cd[d][p*32 +: 32] = md[d][order[p]];
            e_td[d][mt[d][order[p]]] = 1'b1;
            e_gm[d][order[p]] = 1'b1;
        end
        for (int i = 0; i < NR; i++) begin
            e_rdy[d][i] = !halt && (!mv[d][i] || e_gm[d][i]);
            e_pend[d][i] = mv[d][i];
        end
        e_ptr[d] = 3'(mp[d]);
        e_last[d] = (order.size() > 0) ? order[order.size()-1] : -1;
    endtask

    task automatic model_step(input int d);
        if (rst) begin
            for (int i = 0; i < NR; i++) mv[d][i] = 1'b0;
            mp[d] = 0;
        end else if (flush_r) begin
            for (int i = 0; i < NR; i++) mv[d][i] = 1'b0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (valid_r[i] && e_rdy[d][i]) begin
                    mv[d][i] = 1'b1; mt[d][i] = tag_r[i]; md[d][i] = data_r[i];
                end else if (e_gm[d][i]) begin
                    mv[d][i] = 1'b0;
                end
            end
            if (e_last[d] >= 0) mp[d] = (e_last[d] + 1) % NR;
        end
    endtask

    task automatic compare_all();
        check("cdb_valid0", 64'(if0.cdb_valid), 64'(e_cv[0]));
        check("cdb_tag0", 64'(if0.cdb_tag), 64'(e_ct[0]));
        check("cdb_data0", 64'(if0.cdb_data), e_cd[0]);
        check("tag_done0", 64'(if0.tag_done), 64'(e_td[0]));
        check("req_ready0", 64'(if0.req_ready), 64'(e_rdy[0]));
        check("pending0", 64'(if0.pending), 64'(e_pend[0]));
        check("rr_ptr0", 64'(if0.rr_ptr), 64'(e_ptr[0]));
        check("cdb_valid1", 64'(if1.cdb_valid), 64'(e_cv[1]));
        check("cdb_tag1", 64'(if1.cdb_tag), 64'(e_ct[1]));
        check("cdb_data1", 64'(if1.cdb_data), e_cd[1]);
        check("tag_done1", 64'(if1.tag_done), 64'(e_td[1]));
        check("req_ready1", 64'(if1.req_ready), 64'(e_rdy[1]));
        check("pending1", 64'(if1.pending), 64'(e_pend[1]));
        check("rr_ptr1", 64'(if1.rr_ptr), 64'(e_ptr[1]));
    endtask

    // one clock: compare current cycle against the model, then advance both
    task automatic tick();
        #1;
        model_eval(0);
        model_eval(1);
        if (m_init) compare_all();
        model_step(0);
        model_step(1);
        if (rst) m_init = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        valid_r = '0;
        flush_r = 1'b0;
        for (int i = 0; i < NR; i++) begin
            tag_r[i] = 3'($urandom_range(0, 7));
            data_r[i] = $urandom;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cv"}, 64'(if0.cdb_valid), 64'h0);
        check({tag, "_td"}, 64'(if0.tag_done), 64'h0);
        check({tag, "_pend"}, 64'(if0.pending), 64'h0);
        check({tag, "_rdy"}, 64'(if0.req_ready), 64'h1f);
        check({tag, "_ptr"}, 64'(if0.rr_ptr), 64'h0);
        check({tag, "_ct"}, 64'(if0.cdb_tag), 64'h0);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        clear_inputs();

        // single requester
        do_reset();
        check_reset_outputs("rst");
        valid_r = 5'b00100; tag_r[2] = 3'd5; data_r[2] = 32'h0000000B;
        tick();
        clear_inputs();
        check("single_cv", 64'(if0.cdb_valid), 64'h1);
        check("single_tag", 64'(if0.cdb_tag[0]), 64'h5);
        check("single_data", 64'(if0.cdb_data[0]), 64'hB);
        check("single_td", 64'(if0.tag_done), 64'h20);
        tick();
        check("single_idle_cv", 64'(if0.cdb_valid), 64'h0);
        check("single_ptr", 64'(if0.rr_ptr), 64'h3);

        // all five load at once
        do_reset();
        valid_r = 5'b11111;
        for (int i = 0; i < NR; i++) begin tag_r[i] = 3'(i); data_r[i] = 32'(100 + i); end
        tick();
        clear_inputs();
        settle();
        check("all_c1_cv", 64'(if0.cdb_valid), 64'h3);
        check("all_c1_tag", 64'(if0.cdb_tag), 64'({3'd1, 3'd0}));
        check("all_c1_rdy", 64'(if0.req_ready), 64'h03);
        tick();
        check("all_c2_cv", 64'(if0.cdb_valid), 64'h3);
        check("all_c2_tag", 64'(if0.cdb_tag), 64'({3'd3, 3'd2}));
        check("all_c2_rdy", 64'(if0.req_ready), 64'h0f);
        tick();
        check("all_c3_cv", 64'(if0.cdb_valid), 64'h1);
        check("all_c3_tag", 64'(if0.cdb_tag[0]), 64'h4);
        check("all_c3_rdy", 64'(if0.req_ready), 64'h1f);
        tick();
        check("all_ptr_wrap", 64'(if0.rr_ptr), 64'h0);

        // fairness on the single-port instance
        do_reset();
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            valid_r = 5'b00011;
            tag_r[0] = 3'(n % 3);
            tag_r[1] = 3'(3 + (n % 3));
            data_r[0] = $urandom; data_r[1] = $urandom;
            if (n == 2) begin valid_r[3] = 1'b1; tag_r[3] = 3'd7; data_r[3] = 32'h77; end
            tick();
            if (n >= 2 && n <= 4 && if1.cdb_valid[0] && if1.cdb_tag[0] == 3'd7) seen++;
        end
        clear_inputs();
        check("fair_req3_within3", 64'(seen), 64'h1);

        // back-to-back from one requester
        do_reset();
        for (int t = 1; t <= 3; t++) begin
            valid_r = 5'b00001; tag_r[0] = 3'(t); data_r[0] = 32'(t);
            settle();
            check("b2b_ready", 64'(if0.req_ready[0]), 64'h1);
            exp_q.push_back(3'(t));
            tick();
            check("b2b_cv", 64'(if0.cdb_valid[0]), 64'h1);
            check("b2b_tag", 64'(if0.cdb_tag[0]), 64'(exp_q.pop_front()));
        end
        clear_inputs();
        tick();

        // flush with three occupied buffers
        do_reset();
        valid_r = 5'b10101; tag_r[0] = 3'd1; tag_r[2] = 3'd2; tag_r[4] = 3'd3;
        tick();
        clear_inputs();
        flush_r = 1'b1;
        settle();
        check("flush_cv0", 64'(if0.cdb_valid), 64'h0);
        check("flush_cv1", 64'(if1.cdb_valid), 64'h0);
        check("flush_rdy", 64'(if0.req_ready), 64'h0);
        tick();
        flush_r = 1'b0;
        settle();
        check("flush_pend", 64'(if0.pending), 64'h0);
        check("flush_stale", 64'(if0.cdb_valid), 64'h0);
        valid_r = 5'b00010; tag_r[1] = 3'd6; data_r[1] = 32'h66;
        tick();
        clear_inputs();
        check("post_flush_cv", 64'(if0.cdb_valid), 64'h1);
        check("post_flush_tag", 64'(if0.cdb_tag[0]), 64'h6);
        tick();

        // reset while two results are buffered
        valid_r = 5'b01010; tag_r[1] = 3'd2; tag_r[3] = 3'd4;
        tick();
        clear_inputs();
        rst = 1'b1;
        settle();
        check("rst_mid_cv", 64'(if0.cdb_valid), 64'h0);
        tick();
        rst = 1'b0;
        settle();
        check_reset_outputs("rst_mid");

        // randomized traffic with occasional flush and reset
        for (int n = 0; n < 400; n++) begin
            valid_r = 5'($urandom_range(0, 31));
            for (int i = 0; i < NR; i++) begin
                tag_r[i] = 3'($urandom_range(0, 7));
                data_r[i] = $urandom;
            end
            flush_r = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        clear_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
